// File: rtl/alu_pkg.sv
// Shared ALU opcode constants, illegal-opcode predicate and sequencer state enum.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;
  localparam logic [OP_W-1:0] OP_SLL = 4'd5;
  localparam logic [OP_W-1:0] OP_SRL = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } seq_state_e;

  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op > OP_SRL;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that saturates at all-ones; synchronous clear overrides increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one command at a time to an external combinational ALU, waits for it to
// settle, captures the result and holds it until the consumer takes it.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [3:0]       cmd_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_op,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  seq_state_e  state_q, state_d;
  logic [3:0]  settle_q, settle_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_hs;

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (op_illegal(cmd_op)) begin
            // Illegal ops never reach the ALU; answer immediately with an error.
            rsp_result_d = '0;
            rsp_zero_d   = 1'b1;
            rsp_err_d    = 1'b1;
            state_d      = ST_RESP;
          end else begin
            alu_a_d  = cmd_a;
            alu_b_d  = cmd_b;
            alu_op_d = cmd_op;
            settle_d = '0;
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (settle_q == SETTLE_LAST) begin
          rsp_result_d = alu_result;
          rsp_zero_d   = alu_zero;
          rsp_err_d    = 1'b0;
          state_d      = ST_RESP;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      settle_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_hs     = rsp_valid && rsp_ready;

  sat_counter #(.CNT_W(CNT_W)) u_op_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rsp_hs),
    .clr   (cnt_clr),
    .cnt   (op_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rsp_hs && rsp_err_q),
    .clr   (cnt_clr),
    .cnt   (err_cnt)
  );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench: a driver queues expected responses, a monitor checks them and the counters.
module tb_alu_op_sequencer;

  localparam int CW = 4;
  localparam int SETTLE = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [31:0]   cmd_a = '0, cmd_b = '0;
  logic [3:0]    cmd_op = '0;
  logic [31:0]   alu_a, alu_b, alu_result;
  logic [3:0]    alu_op;
  logic          alu_zero;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [31:0]   rsp_result;
  logic          rsp_zero, rsp_err;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] op_cnt, err_cnt;

  logic          cmd_valid3 = 1'b0, cmd_ready3;
  logic [31:0]   cmd_a3 = '0, cmd_b3 = '0;
  logic [3:0]    cmd_op3 = '0;
  logic [31:0]   alu_a3, alu_b3, alu_result3;
  logic [3:0]    alu_op3;
  logic          alu_zero3;
  logic          rsp_valid3, rsp_ready3 = 1'b1;
  logic [31:0]   rsp_result3;
  logic          rsp_zero3, rsp_err3;
  logic [15:0]   op_cnt3, err_cnt3;

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  // Stand-in for the external combinational ALUs.
  assign alu_result  = ref_alu(alu_a, alu_b, alu_op);
  assign alu_zero    = (alu_result == 32'h0);
  assign alu_result3 = ref_alu(alu_a3, alu_b3, alu_op3);
  assign alu_zero3   = (alu_result3 == 32'h0);

  alu_op_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .cnt_clr(cnt_clr),
    .op_cnt(op_cnt), .err_cnt(err_cnt)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_op(cmd_op3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
    .alu_result(alu_result3), .alu_zero(alu_zero3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
    .rsp_zero(rsp_zero3), .rsp_err(rsp_err3), .cnt_clr(1'b0),
    .op_cnt(op_cnt3), .err_cnt(err_cnt3)
  );

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        err;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          rdy_mode = 0;   // 0 always ready, 1 stall 4 cycles, 2 random
  int          clr_mode = 0;   // 0 never, 1 random, 2 on every handshake
  logic [31:0] last_a = '0, last_b = '0;
  logic [3:0]  last_op = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Command fields wiggle freely while the sequencer is busy; they must be ignored.
  task automatic noise();
    cmd_valid = cmd_ready ? 1'b0 : 1'($urandom_range(0, 1));
    cmd_a     = $urandom;
    cmd_b     = $urandom;
    cmd_op    = 4'($urandom_range(0, 15));
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    exp_t e;
    int   n = 0;
    while (!cmd_ready && n < 40) begin
      noise();
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: cmd_ready stayed 0 for %0d cycles, expected 1", n);
      return;
    end
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    e.acc = cyc;
    if (op > 4'd6) begin
      e.res = 32'h0; e.zero = 1'b1; e.err = 1'b1; e.lat = 1;
    end else begin
      e.res = ref_alu(a, b, op); e.zero = (e.res == 32'h0); e.err = 1'b0; e.lat = SETTLE + 1;
      last_a = a; last_b = b; last_op = op;
    end
    e.a = last_a; e.b = last_b; e.op = last_op;
    sb.push_back(e);
    @(negedge clk);
    noise();
  endtask

  task automatic drain();
    int n = 0;
    while (!(sb.size() == 0 && cmd_ready && !rsp_valid) && n < 60) begin
      noise();
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
    end
    cmd_valid = 1'b0;
  endtask

  task automatic random_ops(input int count);
    for (int i = 0; i < count; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      issue($urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom, op);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        noise();
        @(negedge clk);
      end
    end
    drain();
  endtask

  // Monitor: checks responses against the scoreboard and counters against a count model.
  initial begin : monitor
    exp_t cur;
    bit   in_resp = 0;
    int   resp_age = 0;
    int   op_m = 0, err_m = 0;
    bit   hs;
    cur = '{default: 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_resp = 0; op_m = 0; err_m = 0; resp_age = 0;
        rsp_ready = 1'b0;
        cnt_clr = 1'b0;
        continue;
      end
      chk("op_cnt", 64'(op_cnt), 64'(op_m));
      chk("err_cnt", 64'(err_cnt), 64'(err_m));
      if (rsp_valid) begin
        chk("cmd_ready_during_resp", 64'(cmd_ready), 64'd0);
        if (!in_resp) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp: rsp_valid=1 result=0x%0h, expected no response", rsp_result);
          end else begin
            cur = sb.pop_front();
            chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
            chk("alu_a", 64'(alu_a), 64'(cur.a));
            chk("alu_b", 64'(alu_b), 64'(cur.b));
            chk("alu_op", 64'(alu_op), 64'(cur.op));
          end
          in_resp = 1;
          resp_age = 0;
        end else begin
          resp_age++;
        end
        chk("rsp_result", 64'(rsp_result), 64'(cur.res));
        chk("rsp_zero", 64'(rsp_zero), 64'(cur.zero));
        chk("rsp_err", 64'(rsp_err), 64'(cur.err));
      end
      case (rdy_mode)
        0: rsp_ready = 1'b1;
        1: rsp_ready = rsp_valid && (resp_age >= 4);
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
      hs = rsp_valid && rsp_ready;
      case (clr_mode)
        1: cnt_clr = ($urandom_range(0, 7) == 0);
        2: cnt_clr = hs;
        default: cnt_clr = 1'b0;
      endcase
      if (cnt_clr) begin
        op_m = 0;
        err_m = 0;
      end else if (hs) begin
        if (op_m < (1 << CW) - 1) op_m++;
        if (cur.err && err_m < (1 << CW) - 1) err_m++;
      end
      if (hs) in_resp = 0;
    end
  end

  initial begin : main
    int acc3;
    int n;
    @(negedge clk);
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_op_cnt", 64'(op_cnt), 64'd0);
    chk("reset_alu_a", 64'(alu_a), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

    rdy_mode = 0;
    issue(32'd5, 32'd7, 4'd0);
    drain();
    chk("add_op_cnt", 64'(op_cnt), 64'd1);

    rdy_mode = 1;
    issue(32'd9, 32'd9, 4'd1);
    drain();

    rdy_mode = 0;
    issue(32'h1234, 32'h5678, 4'd9);
    drain();
    chk("illegal_err_cnt", 64'(err_cnt), 64'd1);
    chk("illegal_alu_op_kept", 64'(alu_op), 64'd1);

    rdy_mode = 2;
    random_ops(30);
    chk("op_cnt_saturated", 64'(op_cnt), 64'((1 << CW) - 1));

    clr_mode = 2;
    rdy_mode = 0;
    issue(32'd3, 32'd4, 4'd3);
    drain();
    chk("clr_beats_inc", 64'(op_cnt), 64'd0);

    clr_mode = 1;
    rdy_mode = 2;
    random_ops(20);
    clr_mode = 0;

    // Reset while the op is still in ISSUE: it must vanish without a response.
    rdy_mode = 0;
    issue(32'd100, 32'd23, 4'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    chk("rst_rsp_result", 64'(rsp_result), 64'd0);
    chk("rst_op_cnt", 64'(op_cnt), 64'd0);
    sb.delete();
    last_a = '0; last_b = '0; last_op = '0;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    issue(32'hFFFF_FFFF, 32'd1, 4'd0);
    drain();
    chk("post_rst_op_cnt", 64'(op_cnt), 64'd1);

    // Three-cycle settle instance.
    @(negedge clk);
    chk("s3_cmd_ready", 64'(cmd_ready3), 64'd1);
    cmd_a3 = 32'd1; cmd_b3 = 32'd31; cmd_op3 = 4'd5; cmd_valid3 = 1'b1;
    acc3 = cyc;
    @(negedge clk);
    cmd_valid3 = 1'b0;
    cmd_op3 = 4'd0;
    n = 0;
    while (!rsp_valid3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("s3_latency", 64'(cyc - acc3), 64'd4);
    chk("s3_result", 64'(rsp_result3), 64'h8000_0000);
    chk("s3_zero", 64'(rsp_zero3), 64'd0);
    chk("s3_err", 64'(rsp_err3), 64'd0);
    chk("s3_alu_op", 64'(alu_op3), 64'd5);
    @(negedge clk);
    chk("s3_single_rsp", 64'(rsp_valid3), 64'd0);
    chk("s3_op_cnt", 64'(op_cnt3), 64'd1);
    repeat (3) @(negedge clk);
    chk("s3_no_dup_rsp", 64'(rsp_valid3), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
